// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the count monitor.
// Imported by count_wrap_detect and count_monitor.
package count_monitor_pkg;

  localparam int CM_WIDTH     = 8;
  localparam int CM_EVT_WIDTH = 8;

  localparam logic [CM_WIDTH-1:0] CNT_ONES = '1;
  localparam logic [CM_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CM_EVT_WIDTH-1:0] EVT_ONES = '1;
  localparam logic [CM_EVT_WIDTH-1:0] EVT_ZERO = '0;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    PENDING  = 2'd2
  } cm_state_e;

endpackage

// File: rtl/count_wrap_detect.sv
// Tracks the previous count sample and flags overflow,
// underflow and compare match against the current count.
module count_wrap_detect
  import count_monitor_pkg::*;
#(
  parameter int WIDTH = CM_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] cmp_reg,
  output logic             ovf,
  output logic             unf,
  output logic             match
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic             load_q;
  logic             ud_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= ZERO;
      prev_valid <= 1'b0;
      load_q     <= 1'b0;
      ud_q       <= 1'b0;
    end else begin
      prev       <= count;
      prev_valid <= 1'b1;
      load_q     <= load;
      ud_q       <= up_down;
    end
  end

  // load_q/ud_q are the controls that produced the current count
  always_comb begin
    ovf = prev_valid & (prev == ONES) & (count == ZERO)
        & ~load_q & ~ud_q;
    unf = prev_valid & (prev == ZERO) & (count == ONES)
        & ~load_q & ud_q;
    match = (count == cmp_reg)
          & (~prev_valid | (count != prev));
  end

endmodule

// File: rtl/count_monitor.sv
// Counter monitor: wrap/match pulses, wrap tally, irq FSM.
// Optional capture register: COUNT_MONITOR_CAPTURE_EN.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH     = CM_WIDTH,
  parameter int EVT_WIDTH = CM_EVT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     count,
  input  logic                 load,
  input  logic                 up_down,
  input  logic                 cmp_wr,
  input  logic [WIDTH-1:0]     cmp_val,
  input  logic                 irq_en,
  input  logic                 one_shot,
  input  logic                 irq_ack,
  input  logic                 tally_clr,
  output logic                 match_p,
  output logic                 ovf_p,
  output logic                 unf_p,
  output logic [EVT_WIDTH-1:0] wrap_tally,
  output logic                 irq,
  output logic [WIDTH-1:0]     cap_value
);

  localparam logic [EVT_WIDTH-1:0] T_ONES = '1;

  logic [WIDTH-1:0] cmp_reg;
  logic             ovf_d;
  logic             unf_d;
  logic             match_d;
  logic             evt;
  cm_state_e        state_q;
  cm_state_e        state_d;

  count_wrap_detect #(
    .WIDTH (WIDTH)
  ) u_detect (
    .clk     (clk),
    .reset_n (reset_n),
    .count   (count),
    .load    (load),
    .up_down (up_down),
    .cmp_reg (cmp_reg),
    .ovf     (ovf_d),
    .unf     (unf_d),
    .match   (match_d)
  );

  assign evt = ovf_d | unf_d | match_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_reg <= '0;
      match_p <= 1'b0;
      ovf_p   <= 1'b0;
      unf_p   <= 1'b0;
    end else begin
      if (cmp_wr)
        cmp_reg <= cmp_val;
      match_p <= match_d;
      ovf_p   <= ovf_d;
      unf_p   <= unf_d;
    end
  end

  // clear beats a concurrent increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wrap_tally <= '0;
    else if (tally_clr)
      wrap_tally <= '0;
    else if ((ovf_d | unf_d) && wrap_tally != T_ONES)
      wrap_tally <= wrap_tally + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= DISARMED;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!irq_en) begin
      state_d = DISARMED;
    end else begin
      unique case (state_q)
        DISARMED: state_d = ARMED;
        ARMED:
          if (evt)
            state_d = PENDING;
        PENDING:
          if (irq_ack && !evt)
            state_d = one_shot ? DISARMED : ARMED;
        default: state_d = DISARMED;
      endcase
    end
  end

  always_comb begin
    irq = (state_q == PENDING);
  end

`ifdef COUNT_MONITOR_CAPTURE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cap_value <= '0;
    else if (state_q == ARMED && state_d == PENDING)
      cap_value <= count;
  end
`else
  assign cap_value = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Randomized bench for count_monitor with a behavioural
// reference model of the upstream counter and the monitor.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] count;
  logic       load;
  logic       up_down;
  logic       cmp_wr;
  logic [7:0] cmp_val;
  logic       irq_en;
  logic       one_shot;
  logic       irq_ack;
  logic       tally_clr;
  logic       match_p;
  logic       ovf_p;
  logic       unf_p;
  logic [7:0] wrap_tally;
  logic       irq;
  logic [7:0] cap_value;

  always #5 clk = ~clk;

  count_monitor dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .count      (count),
    .load       (load),
    .up_down    (up_down),
    .cmp_wr     (cmp_wr),
    .cmp_val    (cmp_val),
    .irq_en     (irq_en),
    .one_shot   (one_shot),
    .irq_ack    (irq_ack),
    .tally_clr  (tally_clr),
    .match_p    (match_p),
    .ovf_p      (ovf_p),
    .unf_p      (unf_p),
    .wrap_tally (wrap_tally),
    .irq        (irq),
    .cap_value  (cap_value)
  );

  int tests = 0;
  int fails = 0;

  // upstream counter model
  int cnt    = 0;
  int ld_val = 0;
  bit en     = 1'b1;

  // monitor reference model
  int m_prev, m_pv, m_pload, m_pud, m_cmp;
  int m_tally, m_state, m_cap;
  int e_match, e_ovf, e_unf;

  task automatic chk(input string tag, input int got,
                     input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_pv = 0; m_pload = 0; m_pud = 0;
    m_cmp = 0; m_tally = 0; m_state = 0; m_cap = 0;
    e_match = 0; e_ovf = 0; e_unf = 0;
  endtask

  // state codes: 0 disarmed, 1 armed, 2 pending
  task automatic model_edge();
    int c, nst;
    bit any;
    c = int'(count);
    e_ovf = (m_pv != 0 && m_prev == 255 && c == 0
             && m_pload == 0 && m_pud == 0);
    e_unf = (m_pv != 0 && m_prev == 0 && c == 255
             && m_pload == 0 && m_pud == 1);
    e_match = (c == m_cmp && (m_pv == 0 || c != m_prev));
    any = (e_ovf || e_unf || e_match);
    if (tally_clr)
      m_tally = 0;
    else if ((e_ovf || e_unf) && m_tally < 255)
      m_tally++;
    if (!irq_en) nst = 0;
    else if (m_state == 0) nst = 1;
    else if (m_state == 1) nst = any ? 2 : 1;
    else if (irq_ack && !any) nst = one_shot ? 0 : 1;
    else nst = 2;
    if (m_state == 1 && nst == 2) m_cap = c;
    m_state = nst;
    m_prev = c;
    m_pload = int'(load);
    m_pud = int'(up_down);
    m_pv = 1;
    if (cmp_wr) m_cmp = int'(cmp_val);
  endtask

  task automatic check_outs(input string p);
    chk({p, ".match"}, int'(match_p), e_match);
    chk({p, ".ovf"}, int'(ovf_p), e_ovf);
    chk({p, ".unf"}, int'(unf_p), e_unf);
    chk({p, ".tally"}, int'(wrap_tally), m_tally);
    chk({p, ".irq"}, int'(irq), (m_state == 2) ? 1 : 0);
`ifdef COUNT_MONITOR_CAPTURE_EN
    chk({p, ".cap"}, int'(cap_value), m_cap);
`else
    chk({p, ".cap"}, int'(cap_value), 0);
`endif
  endtask

  // one clock: drive counter output, model the edge, check
  task automatic cycle(input string p);
    count = 8'(cnt);
    @(posedge clk);
    model_edge();
    if (load) cnt = ld_val;
    else if (en) cnt = up_down ? (cnt + 255) % 256
                              : (cnt + 1) % 256;
    #1;
    check_outs(p);
    load = 1'b0; cmp_wr = 1'b0;
    irq_ack = 1'b0; tally_clr = 1'b0;
  endtask

  task automatic do_reset(input int start);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst");
    @(posedge clk);
    #1;
    check_outs("rst_hold");
    cnt = start;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; count = 8'h00; load = 1'b0;
    up_down = 1'b0; cmp_wr = 1'b0; cmp_val = 8'h00;
    irq_en = 1'b0; one_shot = 1'b0; irq_ack = 1'b0;
    tally_clr = 1'b0;
    model_reset();
    #2;
    do_reset(8'hFE);

    // overflow counting up FE,FF,00
    en = 1'b1; up_down = 1'b0;
    repeat (3) cycle("s1");
    chk("s1_ovf", int'(ovf_p), 1);
    chk("s1_tally", int'(wrap_tally), 1);

    // underflow counting down 01,00,FF
    load = 1'b1; ld_val = 1; cycle("s2");
    up_down = 1'b1;
    repeat (4) cycle("s2");

    // load 00 over FF: no ovf, match against cmp 00
    up_down = 1'b0;
    cmp_wr = 1'b1; cmp_val = 8'h00;
    load = 1'b1; ld_val = 255; cycle("s3");
    load = 1'b1; ld_val = 0; cycle("s3");
    cycle("s3");
    chk("s3_match", int'(match_p), 1);
    chk("s3_noovf", int'(ovf_p), 0);

    // irq on match at 0x10, ack with concurrent ovf
    irq_en = 1'b1; one_shot = 1'b0;
    cmp_wr = 1'b1; cmp_val = 8'h10;
    load = 1'b1; ld_val = 8'h0E; cycle("s4");
    repeat (3) cycle("s4");
    chk("s4_irq", int'(irq), 1);
    load = 1'b1; ld_val = 255; cycle("s4");
    cycle("s4");
    irq_ack = 1'b1; cycle("s4");
    chk("s4_ack_ovf", int'(irq), 1);
    irq_ack = 1'b1; cycle("s4");
    chk("s4_ack", int'(irq), 0);

    // one-shot, then irq_en drop during PENDING
    one_shot = 1'b1;
    load = 1'b1; ld_val = 8'h0F; cycle("s5");
    repeat (2) cycle("s5");
    irq_ack = 1'b1; cycle("s5");
    repeat (2) cycle("s5");
    load = 1'b1; ld_val = 8'h0F; cycle("s5");
    repeat (2) cycle("s5");
    irq_en = 1'b0; cycle("s5");
    chk("s5_en_off", int'(irq), 0);

    // tally saturation via load FF / count up pairs
    irq_en = 1'b1; one_shot = 1'b0;
    load = 1'b1; ld_val = 255; cycle("s6");
    cycle("s6");
    repeat (260) begin
      load = 1'b1; ld_val = 255; cycle("s6");
      cycle("s6");
    end
    chk("s6_sat", int'(wrap_tally), 255);
    load = 1'b1; ld_val = 255; cycle("s6");
    cycle("s6");
    tally_clr = 1'b1; cycle("s6");
    chk("s6_clr", int'(wrap_tally), 0);

    // reset mid-count, first sample is 00 after FF
    load = 1'b1; ld_val = 255; cycle("s7");
    cycle("s7");
    do_reset(0);
    cycle("s7");
    chk("s7_noovf", int'(ovf_p), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        load = 1'b1;
        r = int'($urandom_range(0, 3));
        ld_val = (r == 0) ? 0 : (r == 1) ? 255 :
                 (r == 2) ? m_cmp : int'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 15) == 0) up_down = ~up_down;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) begin
        cmp_wr = 1'b1;
        cmp_val = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 63) == 0) irq_en = ~irq_en;
      if ($urandom_range(0, 31) == 0) one_shot = ~one_shot;
      irq_ack = ($urandom_range(0, 3) == 0);
      tally_clr = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 999) == 0)
        do_reset(int'($urandom_range(0, 255)));
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
